// File: rtl/register_read_port.sv
// Read-side controller for the 16 x 32-bit register file: req/ack in, valid/ready out,
// with write-forwarding at capture time. Define R0_ZERO_EN to make reads of R0 return zero.
module register_read_port #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [NREG*DATA_W-1:0] q_flat,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_req,
    input  logic [3:0]             rd_addr,
    output logic                   rd_ack,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic [3:0]             rd_tag,
    output logic                   bus_drive_en,
    output logic                   busy,
    output logic [CNT_W-1:0]       rd_count
);

    // state   | meaning
    // IDLE    | waiting for rd_req
    // CAPTURE | one cycle: sample selected register (or forwarded write) into rd_data
    // HOLD    | rd_data valid and driven on the bus until rd_ready
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    logic [1:0]        r_state;
    logic [3:0]        r_addr;
    logic              r_ack;
    logic              r_valid;
    logic              r_bus_en;
    logic              r_busy;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_tag;
    logic [CNT_W-1:0]  r_count;

    logic [DATA_W-1:0] w_q_arr [NREG];
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_cap_data;

    for (genvar g = 0; g < NREG; g++) begin : g_unpack
        assign w_q_arr[g] = q_flat[g*DATA_W +: DATA_W];
    end

    assign w_fwd_hit = wr_en && (wr_addr == r_addr);

    always_comb begin
        w_cap_data = w_q_arr[r_addr];
        if (w_fwd_hit) begin
            w_cap_data = wr_data;
        end
`ifdef R0_ZERO_EN
        // Base-register-zero: R0 overrides both the file output and forwarding
        if (r_addr == 4'd0) begin
            w_cap_data = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_ack    <= 1'b0;
            r_valid  <= 1'b0;
            r_bus_en <= 1'b0;
            r_busy   <= 1'b0;
            r_data   <= '0;
            r_tag    <= '0;
            r_count  <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rd_req) begin
                        r_addr  <= rd_addr;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_data   <= w_cap_data;
                    r_tag    <= r_addr;
                    r_valid  <= 1'b1;
                    r_bus_en <= 1'b1;
                    r_busy   <= 1'b1;
                    r_state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (rd_ready) begin
                        if (r_count != {CNT_W{1'b1}}) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                        r_valid  <= 1'b0;
                        r_bus_en <= 1'b0;
                        if (rd_req) begin
                            r_addr  <= rd_addr;
                            r_ack   <= 1'b1;
                            r_state <= S_CAPTURE;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_valid  <= 1'b0;
                    r_bus_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_ack       = r_ack;
    assign rd_valid     = r_valid;
    assign bus_drive_en = r_bus_en;
    assign busy         = r_busy;
    assign rd_data      = r_data;
    assign rd_tag       = r_tag;
    assign rd_count     = r_count;

endmodule
